// File: rtl/count_sequencer.sv
// Control FSM for the 8-bit toggle-flip-flop counter: start/stop/pause control,
// a programmable prescaler for the count rate, and one-shot or modulo terminal handling.
module count_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_pause,
    input  logic                 i_mode,
    input  logic [DIV_WIDTH-1:0] i_rateDiv,
    input  logic [WIDTH-1:0]     i_terminalValue,
    input  logic [WIDTH-1:0]     i_counterValue,
    output logic                 o_countEnable,
    output logic                 o_countClear_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] PRESC_ONE = 1;

    state_t               r_state;
    state_t               w_nextState;
    logic [DIV_WIDTH-1:0] r_prescaler;
    logic [DIV_WIDTH-1:0] w_nextPrescaler;
    logic                 r_mode;
    logic [DIV_WIDTH-1:0] r_rateDiv;
    logic [WIDTH-1:0]     r_termValue;
    logic                 r_wrap;
    logic                 w_nextWrap;
    logic                 w_latch;
    logic                 w_tick;
    logic                 w_term;
    logic                 w_countEnable;

    assign w_tick = (r_prescaler >= r_rateDiv) && !i_pause;
    assign w_term = (i_counterValue == r_termValue);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_prescaler <= '0;
            r_mode      <= 1'b0;
            r_rateDiv   <= '0;
            r_termValue <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_prescaler <= w_nextPrescaler;
            r_wrap      <= w_nextWrap;
            if (w_latch) begin
                r_mode      <= i_mode;
                r_rateDiv   <= i_rateDiv;
                r_termValue <= i_terminalValue;
            end
        end
    end

    // The if-chains encode precedence: Stop, then Start, then terminal handling.
    always_comb begin
        w_nextState     = r_state;
        w_nextPrescaler = r_prescaler;
        w_nextWrap      = 1'b0;
        w_latch         = 1'b0;
        w_countEnable   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_stop && i_start) begin
                    w_latch     = 1'b1;
                    w_nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_nextPrescaler = '0;
                w_nextState     = i_stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (!i_pause) begin
                    w_nextPrescaler = w_tick ? '0 : r_prescaler + PRESC_ONE;
                end
                w_countEnable = !i_stop && w_tick && !w_term;
                if (i_stop) begin
                    w_nextState = ST_IDLE;
                end else if (i_start) begin
                    w_latch     = 1'b1;
                    w_nextState = ST_CLEAR;
                end else if (!r_mode && w_term) begin
                    w_nextState = ST_DONE;
                end else if (r_mode && w_tick && w_term) begin
                    w_nextState = ST_CLEAR;
                    w_nextWrap  = 1'b1;
                end
            end
            ST_DONE: begin
                if (i_stop) begin
                    w_nextState = ST_IDLE;
                end else if (i_start) begin
                    w_latch     = 1'b1;
                    w_nextState = ST_CLEAR;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Everything except the enable comes from registered state only.
    assign o_countEnable  = w_countEnable;
    assign o_countClear_b = (r_state != ST_CLEAR);
    assign o_busy         = (r_state == ST_CLEAR) || (r_state == ST_RUN);
    assign o_done         = (r_state == ST_DONE) || ((r_state == ST_CLEAR) && r_wrap);
    assign o_state        = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer, with a behavioural model of the
// toggle-flip-flop counter (asynchronous active-low clear) closing the loop.
module tb_count_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop, pause, mode;
    logic [15:0] rateDiv;
    logic [7:0]  terminalValue;
    logic [7:0]  counterValue = '0;
    logic        countEnable, countClear_b, busy, done;
    logic [1:0]  state;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        bit          rst, start, stop, pause, mode;
        logic [15:0] div;
        logic [7:0]  tv;
        bit          chk;
        logic [1:0]  st;
        logic        en, clrb, busy, done;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(8), .DIV_WIDTH(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_stop         (stop),
        .i_pause        (pause),
        .i_mode         (mode),
        .i_rateDiv      (rateDiv),
        .i_terminalValue(terminalValue),
        .i_counterValue (counterValue),
        .o_countEnable  (countEnable),
        .o_countClear_b (countClear_b),
        .o_busy         (busy),
        .o_done         (done),
        .o_state        (state)
    );

    always @(posedge clk or negedge countClear_b) begin
        if (!countClear_b) counterValue <= '0;
        else if (countEnable) counterValue <= counterValue + 8'd1;
    end

    function automatic vec_t mkVec(bit r, bit s, bit t, bit p, bit m, int dv, int tv,
                                   bit c, int st, bit en, bit clrb, bit bz, bit dn, int cnt);
        vec_t v;
        v.rst = r; v.start = s; v.stop = t; v.pause = p; v.mode = m;
        v.div = 16'(dv); v.tv = 8'(tv); v.chk = c;
        v.st = 2'(st); v.en = en; v.clrb = clrb; v.busy = bz; v.done = dn; v.cnt = 8'(cnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = v.rst; start = v.start; stop = v.stop; pause = v.pause;
        mode = v.mode; rateDiv = v.div; terminalValue = v.tv;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        #1;
        if (v.chk) begin
            testsRun++;
            if ({state, countEnable, countClear_b, busy, done, counterValue} !==
                {v.st, v.en, v.clrb, v.busy, v.done, v.cnt}) begin
                testsFailed++;
                $display("[TB] FAIL %s: got st=%0d en=%0b clrb=%0b busy=%0b done=%0b cnt=%0d, expected st=%0d en=%0b clrb=%0b busy=%0b done=%0b cnt=%0d",
                         name, state, countEnable, countClear_b, busy, done, counterValue,
                         v.st, v.en, v.clrb, v.busy, v.done, v.cnt);
            end
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    initial begin
        vec_t v;
        int   cnt;
        bit   en;
        int   m;

        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
        rateDiv = '0; terminalValue = '0;

        // Reset, idle, then a one-shot run to 5 with the inputs scrambled after Start.
        for (int i = 0; i < 2; i++) vecs.push_back(mkVec(1,0,0,0,0,0,0, 0, 0,0,1,0,0,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mkVec(0,0,0,0,0,0,0, 1, 0,0,1,0,0,0));
        vecs.push_back(mkVec(0,1,0,0,0,0,5, 1, 0,0,1,0,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,7,0, 1, 1,0,0,1,0,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mkVec(0,0,0,0,0,7,0, 1, 2,1,1,1,0,i));
        vecs.push_back(mkVec(0,0,0,0,0,7,0, 1, 2,0,1,1,0,5));
        vecs.push_back(mkVec(0,0,0,0,0,7,0, 1, 3,0,1,0,1,5));
        for (int i = 0; i < 2; i++) vecs.push_back(mkVec(0,0,0,0,0,7,0, 1, 0,0,1,0,0,5));
        // Stop at 7, Start+Stop together, then a clean restart interrupted by Start in RUN.
        vecs.push_back(mkVec(0,1,0,0,0,0,20, 1, 0,0,1,0,0,5));
        vecs.push_back(mkVec(0,0,0,0,0,0,20, 1, 1,0,0,1,0,0));
        for (int i = 0; i < 7; i++) vecs.push_back(mkVec(0,0,0,0,0,0,20, 1, 2,1,1,1,0,i));
        vecs.push_back(mkVec(0,0,1,0,0,0,20, 1, 2,0,1,1,0,7));
        vecs.push_back(mkVec(0,1,1,0,0,0,20, 1, 0,0,1,0,0,7));
        vecs.push_back(mkVec(0,0,0,0,0,0,20, 1, 0,0,1,0,0,7));
        vecs.push_back(mkVec(0,1,0,0,0,0,20, 1, 0,0,1,0,0,7));
        vecs.push_back(mkVec(0,0,0,0,0,0,20, 1, 1,0,0,1,0,0));
        for (int i = 0; i < 2; i++) vecs.push_back(mkVec(0,0,0,0,0,0,20, 1, 2,1,1,1,0,i));
        vecs.push_back(mkVec(0,1,0,0,0,0,0, 1, 2,1,1,1,0,2));
        // Restart latched TerminalValue=0: DONE straight from the first RUN cycle.
        vecs.push_back(mkVec(0,0,0,0,0,0,0, 1, 1,0,0,1,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0, 1, 2,0,1,1,0,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0, 1, 3,0,1,0,1,0));
        vecs.push_back(mkVec(0,0,0,0,0,0,0, 1, 0,0,1,0,0,0));
        // Reset landing in the CLEAR cycle.
        vecs.push_back(mkVec(0,1,0,0,0,0,5, 1, 0,0,1,0,0,0));
        vecs.push_back(mkVec(1,0,0,0,0,0,5, 1, 1,0,0,1,0,0));
        for (int i = 0; i < 2; i++) vecs.push_back(mkVec(0,0,0,0,0,0,5, 1, 0,0,1,0,0,0));

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

        // Continuous, RateDiv=2, TerminalValue=3: 13-cycle period starting at CLEAR.
        runVec(mkVec(0,1,0,0,1,2,3, 1, 0,0,1,0,0,0), "cont start");
        for (int k = 0; k < 40; k++) begin
            m = k % 13;
            if (m == 0) begin
                v = mkVec(0,0,0,0,0,0,1, 1, 1,0,0,1,(k != 0),0);
            end else begin
                cnt = (m - 1) / 3;
                en  = ((m - 1) % 3 == 2) && (cnt != 3);
                v = mkVec(0,0,0,0,0,0,1, 1, 2,en,1,1,0,cnt);
            end
            runVec(v, $sformatf("cont k=%0d", k));
        end
        runVec(mkVec(0,0,1,0,0,0,1, 1, 2,0,1,1,0,0), "cont stop");
        runVec(mkVec(0,0,0,0,0,0,1, 1, 0,0,1,0,0,0), "cont idle");

        // One-shot, RateDiv=1, TerminalValue=10, paused for 6 cycles as 4 appears.
        runVec(mkVec(0,1,0,0,0,1,10, 1, 0,0,1,0,0,0), "pause start");
        runVec(mkVec(0,0,0,0,0,1,10, 1, 1,0,0,1,0,0), "pause clear");
        for (int r = 0; r < 29; r++) begin
            bit p;
            p = (r >= 8) && (r <= 13);
            if (r < 8) begin
                cnt = r / 2;
                en  = (r % 2 == 1);
            end else if (r <= 13) begin
                cnt = 4;
                en  = 1'b0;
            end else begin
                cnt = 4 + (r - 14) / 2;
                en  = ((r - 14) % 2 == 1) && (cnt != 10);
            end
            if (r <= 26)      v = mkVec(0,0,0,p,0,1,10, 1, 2,en,1,1,0,cnt);
            else if (r == 27) v = mkVec(0,0,0,0,0,1,10, 1, 3,0,1,0,1,10);
            else              v = mkVec(0,0,0,0,0,1,10, 1, 0,0,1,0,0,10);
            runVec(v, $sformatf("pause r=%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Control FSM that drives the 8-bit toggle-flip-flop counter block. It outputs that counter's Enable and Clear_b, and reads back its CounterValue. It provides start, stop and pause control, a programmable prescaler that sets the count rate, and terminal-count handling. Terminal handling is either one-shot (stop at a value) or continuous (modulo, count 0..TerminalValue). It sits between the user controls (switches/keys) and the counter datapath.

Parameters:
WIDTH, 8, counter width; must match the counter block.
DIV_WIDTH, 16, prescaler width.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  level; starts or restarts a count sequence.
Stop  input  1  level; aborts to IDLE.
Pause  input  1  level; freezes counting while in RUN.
Mode  input  1  0 = one-shot, 1 = continuous; latched on Start.
RateDiv  input  DIV_WIDTH  one count per RateDiv+1 cycles; latched on Start.
TerminalValue  input  WIDTH  terminal count; latched on Start.
CounterValue  input  WIDTH  current value fed back from the counter.
CountEnable  output  1  drives the counter Enable.
CountClear_b  output  1  drives the counter active-low Clear_b.
Busy  output  1  high in CLEAR or RUN.
Done  output  1  one-cycle pulse on a terminal event.
State  output  2  IDLE=0, CLEAR=1, RUN=2, DONE=3.

Behaviour:
- Reset (checked only at a rising edge while Reset=1):
  - State=IDLE, prescaler=0, latched Mode/RateDiv/TerminalValue=0.
  - Outputs: CountEnable=0, CountClear_b=1, Busy=0, Done=0.
- Priority each cycle: Reset > Stop > Start > terminal event > Pause.
- IDLE:
  - CountEnable=0, CountClear_b=1.
  - Start=1 latches Mode/RateDiv/TerminalValue, then next state is CLEAR.
  - The counter value is left untouched.
- CLEAR:
  - Lasts exactly 1 cycle.
  - CountClear_b=0 (decoded from registered state only, glitch-free).
  - Prescaler is set to 0; next state is RUN.
- RUN:
  - The prescaler increments each cycle unless Pause=1.
  - tick = (prescaler >= latched RateDiv) && !Pause.
  - On tick the prescaler returns to 0.
  - RateDiv=0 gives a tick every unpaused cycle.
- Terminal handling, where term = (CounterValue == latched TerminalValue):
  - One-shot: CountEnable = tick && !term. If term in RUN, next state is DONE, independent of tick and Pause.
  - Continuous: CountEnable = tick && !term. If tick && term, next state is CLEAR and Done=1 in that CLEAR cycle.
  - Result in continuous mode: value 0 is held RateDiv+2 cycles (CLEAR + full period); every other value is held RateDiv+1 cycles.
- DONE:
  - Lasts exactly 1 cycle; Done=1, CountEnable=0.
  - Next state is IDLE, or CLEAR if Start=1.
  - The counter holds TerminalValue.
- Done is decoded from registered state plus a registered wrap flag; it is never combinational from inputs.
- CountEnable is the only output that depends combinationally on inputs (Pause, CounterValue).
- Stop=1 in any state: next state is IDLE, CountEnable=0 that cycle, counter value retained, no Done pulse.
- Start=1 while in RUN (Stop=0): restart; next state is CLEAR and parameters are re-latched.
- Start and Stop both 1: Stop wins.
- Pause while in CLEAR has no effect. Pause held forever in RUN gives no enables and a frozen prescaler. A one-shot terminal is still detected while paused.
- One-shot with TerminalValue=0: RUN sees term in its first cycle, goes to DONE, and issues no enables.
- Changing RateDiv, Mode or TerminalValue on the inputs mid-run has no effect until the next Start.
- Reset in any state (including CLEAR) forces IDLE next cycle. CountClear_b=1 from that cycle on.

Test Plan:
- Reset for 2 cycles, then idle for 5 cycles → State=0, CountEnable=0, CountClear_b=1, Busy=0, Done=0 throughout.
- Mode=0, RateDiv=0, TerminalValue=5, Start for 1 cycle → CountClear_b low for 1 cycle; 5 consecutive CountEnable pulses; counter reaches 5; Done for 1 cycle; State returns to 0; counter stays 5.
- Mode=1, RateDiv=2, TerminalValue=3, run 40 cycles → counter sequence 0,1,2,3,0,…; Done once per wrap; values 1–3 held 3 cycles each, 0 held 4 cycles.
- Mode=0, RateDiv=1, TerminalValue=10, Pause for 6 cycles at count 4 → no enables while paused, prescaler frozen, counting resumes on release, ends at 10 with Done.
- Stop asserted at count 7, Start and Stop together, then Start alone during RUN → IDLE with value 7 kept, no Done; simultaneous case stays IDLE; lone Start gives CLEAR (counter 0) and restart.
- Mode=0, TerminalValue=0; plus Reset asserted mid-CLEAR → DONE with zero enables; after the mid-CLEAR Reset, State=0 and CountClear_b=1 on the next cycle.
